// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and divider state encoding
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DATA_W-1:0] DIV_ZERO_QUOTIENT = {DATA_W{1'b1}};

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle
interface seq_divider_if #(
    parameter int DATA_W = alu_pkg::DATA_W
);
    logic              start;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] Quotient;
    logic [DATA_W-1:0] Remainder;
    logic              DivZero;
    logic              busy;
    logic              done;

    modport master (
        output start, A, B,
        input  Quotient, Remainder, DivZero, busy, done
    );

    modport slave (
        input  start, A, B,
        output Quotient, Remainder, DivZero, busy, done
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] q_next
);
    logic [DATA_W-1:0] rem_shifted;
    logic [DATA_W:0]   trial;
    logic              borrow;

    // Shift {rem,q} left one bit and trial-subtract the divisor; the extra
    // MSB of the subtract is the borrow-out. On borrow the shifted value is
    // kept (the restore), otherwise the difference replaces it.
    always_comb begin
        rem_shifted = {rem[DATA_W-2:0], q[DATA_W-1]};
        trial       = {1'b0, rem_shifted} - {1'b0, B};
        borrow      = trial[DATA_W];
        rem_next    = borrow ? rem_shifted : trial[DATA_W-1:0];
        q_next      = {q[DATA_W-2:0], ~borrow};
    end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one bit per clock
module seq_divider #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t        state;
    div_state_t        state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] rmd_r;
    logic              dz_r;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] q_next;
    logic              accept;
    logic              b_zero;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .B        (b_r),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign b_zero = (bus.B == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: a start in IDLE or DONE is accepted; DONE lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start)          state_next = b_zero ? DONE : RUN;
                else if (state == DONE) state_next = IDLE;
            end
            RUN: begin
                if (count == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration registers and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rem_r <= '0;
            q_r   <= '0;
            b_r   <= '0;
            quo_r <= '0;
            rmd_r <= '0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            b_r   <= bus.B;
            q_r   <= bus.A;
            rem_r <= '0;
            count <= CNT_LAST;
            if (b_zero) begin
                quo_r <= {DATA_W{1'b1}};
                rmd_r <= bus.A;
                dz_r  <= 1'b1;
            end else begin
                quo_r <= '0;
                dz_r  <= 1'b0;
            end
        end else if (state == RUN) begin
            rem_r <= rem_next;
            q_r   <= q_next;
            if (count == '0) begin
                quo_r <= q_next;
                rmd_r <= rem_next;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.Quotient  = quo_r;
    assign bus.Remainder = rmd_r;
    assign bus.DivZero   = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if bus ();

    seq_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge from the current negedge, then sample at each
    // negedge until done (bounded). Returns the negedge count at done and
    // whether busy ever disagreed with the expected RUN window.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int n, output bit busy_err);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        busy_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy !== (b != 0)) busy_err = 1'b1;
            @(negedge clk);
            n++;
        end
        if (bus.done === 1'b1 && bus.busy !== 1'b0) busy_err = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.Quotient, bus.Remainder, bus.DivZero, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%0h r=%0h dz=%0b busy=%0b done=%0b exp all 0",
                     bus.Quotient, bus.Remainder, bus.DivZero, bus.busy, bus.done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        bit be;
        do_op(32'd100, 32'd7, n, be);
        checks++; if (n !== 33) begin errors++; $display("FAIL basic_latency got %0d exp 33", n); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL basic_busy got err=%0b exp 0", be); end
        checks++; if (bus.Quotient !== 32'd14) begin errors++; $display("FAIL basic_q got %0d exp 14", bus.Quotient); end
        checks++; if (bus.Remainder !== 32'd2) begin errors++; $display("FAIL basic_r got %0d exp 2", bus.Remainder); end
        checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL basic_dz got %0b exp 0", bus.DivZero); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %0b exp 0", bus.done); end
        checks++; if (bus.Quotient !== 32'd14) begin errors++; $display("FAIL basic_hold got %0d exp 14", bus.Quotient); end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] tb [3] = '{32'd1, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] tq [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] tr [3] = '{32'd0, 32'd0, 32'd5};
        int n;
        bit be;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], n, be);
            checks++;
            if (bus.Quotient !== tq[i] || bus.Remainder !== tr[i] || n !== 33) begin
                errors++;
                $display("FAIL boundary_%0d got q=%0h r=%0h n=%0d exp q=%0h r=%0h n=33",
                         i, bus.Quotient, bus.Remainder, n, tq[i], tr[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        int n;
        bit be;
        do_op(32'd1234, 32'd0, n, be);
        checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", n); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL dz_busy got err=%0b exp 0", be); end
        checks++; if (bus.Quotient !== DIV_ZERO_QUOTIENT) begin errors++; $display("FAIL dz_q got %0h exp ffffffff", bus.Quotient); end
        checks++; if (bus.Remainder !== 32'd1234) begin errors++; $display("FAIL dz_r got %0d exp 1234", bus.Remainder); end
        checks++; if (bus.DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b exp 1", bus.DivZero); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dz_after got done=%0b busy=%0b exp 0 0", bus.done, bus.busy); end
        checks++; if (bus.DivZero !== 1'b1) begin errors++; $display("FAIL dz_hold got %0b exp 1", bus.DivZero); end
        do_op(32'd20, 32'd4, n, be);
        checks++;
        if (bus.DivZero !== 1'b0 || bus.Quotient !== 32'd5 || bus.Remainder !== 32'd0) begin
            errors++;
            $display("FAIL dz_clear got dz=%0b q=%0d r=%0d exp 0 5 0", bus.DivZero, bus.Quotient, bus.Remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        bit be;
        bit seen = 1'b0;
        bus.A = 32'd77;
        bus.B = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Quotient, bus.Remainder, bus.DivZero, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL abort_clear got q=%0h r=%0h dz=%0b busy=%0b done=%0b exp all 0",
                     bus.Quotient, bus.Remainder, bus.DivZero, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0b exp 0", seen); end
        do_op(32'd50, 32'd5, n, be);
        checks++;
        if (bus.Quotient !== 32'd10 || bus.Remainder !== 32'd0 || n !== 33) begin
            errors++;
            $display("FAIL abort_next got q=%0d r=%0d n=%0d exp 10 0 33", bus.Quotient, bus.Remainder, n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.A = 32'd1000;
        bus.B = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.done !== 1'b1) begin
                bus.A = $urandom;
                bus.B = $urandom;
            end
        end while (bus.done !== 1'b1 && n < 60);
        checks++;
        if (bus.Quotient !== 32'd333 || bus.Remainder !== 32'd1 || n !== 33) begin
            errors++;
            $display("FAIL ignore_run got q=%0d r=%0d n=%0d exp 333 1 33", bus.Quotient, bus.Remainder, n);
        end
        bus.A = 32'd81;
        bus.B = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%0b exp 1", bus.busy); end
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.Quotient !== 32'd9 || bus.Remainder !== 32'd0 || n !== 33) begin
            errors++;
            $display("FAIL b2b_result got q=%0d r=%0d n=%0d exp 9 0 33", bus.Quotient, bus.Remainder, n);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        bit be;
        logic [31:0] a, b, eq, er;
        logic edz;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            case ($urandom_range(0, 15))
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 255);
                4:       b = a;
                5:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1000);
            if (b == 0) begin
                eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0;
            end
            do_op(a, b, n, be);
            checks++;
            if (bus.Quotient !== eq || bus.Remainder !== er || bus.DivZero !== edz) begin
                errors++;
                $display("FAIL rand_result a=%0h b=%0h got q=%0h r=%0h dz=%0b exp q=%0h r=%0h dz=%0b",
                         a, b, bus.Quotient, bus.Remainder, bus.DivZero, eq, er, edz);
            end
            checks++;
            if (n !== ((b == 0) ? 1 : 33) || be !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing a=%0h b=%0h got n=%0d busy_err=%0b exp n=%0d busy_err=0",
                         a, b, n, be, (b == 0) ? 1 : 33);
            end
            if (b != 0) begin
                checks++;
                if ({32'd0, a} !== 64'(bus.Quotient) * 64'(b) + 64'(bus.Remainder) || bus.Remainder >= b) begin
                    errors++;
                    $display("FAIL rand_invariant a=%0h b=%0h got q=%0h r=%0h", a, b, bus.Quotient, bus.Remainder);
                end
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL rand_done_width got %0b exp 0", bus.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
